global_control_ng: RTL and testbench

Second-generation global control peripheral on the Uniboard register bus. It combines a parametrised set of active-low pause inputs, a software force-pause, a host-link watchdog and a battery undervoltage monitor with hysteresis into one registered `global_pause` output. It also keeps the uptime counter, reports build and API identifiers, and drives the status LED blink pattern. It is instantiated once in the top level, in the slot held by the first-generation global control peripheral.

---
 rtl/global_control_ng_if.sv | 24 ++
 rtl/global_control_ng.sv | 179 +++++++++++++++++
 tb/tb_global_control_ng.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/global_control_ng_if.sv
// Uniboard register bus as seen by one peripheral. The shared databus and the
// reg_size reply are resolved here, from the enables each side supplies.
interface global_control_ng_if;
  wire  [31:0] databus;
  wire  [2:0]  reg_size;
  logic [7:0]  register_addr;
  logic        rw;
  logic        select;
  logic [31:0] master_wdata;
  logic        master_oe;
  logic [31:0] slave_rdata;
  logic        slave_oe;
  logic [2:0]  slave_size;
  logic        slave_size_oe;

  assign databus  = master_oe     ? master_wdata : 32'bz;
  assign databus  = slave_oe      ? slave_rdata  : 32'bz;
  assign reg_size = slave_size_oe ? slave_size   : 3'bz;

  modport master (inout databus, input reg_size,
                  output register_addr, rw, select, master_wdata, master_oe);
  modport slave  (input databus, register_addr, rw, select,
                  output slave_rdata, slave_oe, slave_size, slave_size_oe);
endinterface

// File: rtl/global_control_ng.sv
// Global control peripheral: merges pause sources, watchdog and battery monitor
// into global_pause, and provides uptime, identifiers and the status LED pattern.
module global_control_ng #(
  parameter int unsigned CLK_HZ         = 12000000,
  parameter int unsigned NUM_PAUSE_SRC  = 2,
  parameter int unsigned WDT_TIMEOUT_MS = 500,
  parameter logic [31:0] HDL_BUILD      = 32'd0,
  parameter logic [31:0] API_VERSION    = 32'h000A
) (
  input  logic                     clk_12MHz,
  input  logic                     reset,
  global_control_ng_if.slave       bus,
  input  logic [NUM_PAUSE_SRC-1:0] pause_n_in,
  input  logic [15:0]              battery_voltage,
  output logic                     global_pause,
  output logic                     status_led
);
  localparam int unsigned     MS_DIV    = CLK_HZ / 1000;
  localparam int unsigned     PRESC_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(MS_DIV - 1);
  localparam logic [15:0]     WDT_LIMIT = 16'(WDT_TIMEOUT_MS);

  logic [PRESC_W-1:0]       presc;
  logic                     ms_tick;
  logic [9:0]               blink_ms;
  logic [31:0]              uptime;
  logic [NUM_PAUSE_SRC-1:0] sync1, sync2, live, sticky, sticky_clr;
  logic                     select_prev, access, wr, wr_valid, wdt_clear;
  logic                     force_pause, wdt_enable, wdt_expired, undervoltage;
  logic [15:0]              uv_threshold, uv_hysteresis, wdt_count;
  logic [16:0]              uv_release;
  logic                     fast_on, slow_on;
  logic [31:0]              rd_value, read_value;
  logic [2:0]               rd_size, read_size;

  assign ms_tick    = (presc == PRESC_MAX);
  assign live       = ~sync2;
  assign access     = bus.select & ~select_prev;
  assign wr         = access & ~bus.rw;
  assign wr_valid   = wr & (bus.register_addr <= 8'd9);
  assign wdt_clear  = wr_valid | ~wdt_enable;
  assign sticky_clr = (wr && bus.register_addr == 8'd6) ? bus.databus[NUM_PAUSE_SRC-1:0] : '0;
  assign uv_release = {1'b0, uv_threshold} + {1'b0, uv_hysteresis};

  // blink_ms doubles as the LED phase and the sub-second part of uptime
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      presc    <= '0;
      blink_ms <= '0;
      uptime   <= '0;
    end else if (ms_tick) begin
      presc <= '0;
      if (blink_ms == 10'd999) begin
        blink_ms <= '0;
        uptime   <= uptime + 32'd1;
      end else begin
        blink_ms <= blink_ms + 10'd1;
      end
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      sticky <= '0;
    end else begin
      sync1  <= pause_n_in;
      sync2  <= sync1;
      sticky <= (sticky & ~sticky_clr) | live;
    end
  end

  // Tracks select through reset so a held select never looks like a new access
  always_ff @(posedge clk_12MHz) begin
    select_prev <= bus.select;
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      force_pause   <= 1'b0;
      wdt_enable    <= 1'b0;
      uv_threshold  <= '0;
      uv_hysteresis <= '0;
    end else if (wr) begin
      case (bus.register_addr)
        8'd0: begin
          force_pause <= bus.databus[1];
          wdt_enable  <= bus.databus[4];
        end
        8'd7:    uv_threshold  <= bus.databus[15:0];
        8'd8:    uv_hysteresis <= bus.databus[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      wdt_count   <= '0;
      wdt_expired <= 1'b0;
    end else begin
      if (wdt_clear) begin
        wdt_count <= '0;
      end else if (ms_tick && wdt_count != WDT_LIMIT) begin
        wdt_count <= wdt_count + 16'd1;
      end
      if (wr && bus.register_addr == 8'd0 && bus.databus[2]) begin
        wdt_expired <= 1'b0;
      end else if (!wdt_clear && ms_tick && wdt_count == WDT_LIMIT - 16'd1) begin
        wdt_expired <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset || uv_threshold == 16'd0) begin
      undervoltage <= 1'b0;
    end else if (battery_voltage < uv_threshold) begin
      undervoltage <= 1'b1;
    end else if ({1'b0, battery_voltage} >= uv_release) begin
      undervoltage <= 1'b0;
    end
  end

  assign fast_on = (blink_ms < 10'd125) ||
                   (blink_ms >= 10'd250 && blink_ms < 10'd375) ||
                   (blink_ms >= 10'd500 && blink_ms < 10'd625) ||
                   (blink_ms >= 10'd750 && blink_ms < 10'd875);
  assign slow_on = (blink_ms < 10'd500);

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      global_pause <= 1'b1;
      status_led   <= 1'b0;
    end else begin
      global_pause <= force_pause | (|live) | wdt_expired | undervoltage;
      status_led   <= undervoltage ? fast_on : (global_pause ? slow_on : 1'b1);
    end
  end

  always_comb begin
    rd_value = '0;
    rd_size  = 3'd0;
    case (bus.register_addr)
      8'd0: begin
        rd_value = {27'd0, wdt_enable, undervoltage, wdt_expired, force_pause, global_pause};
        rd_size  = 3'd1;
      end
      8'd1: begin rd_value = {16'd0, battery_voltage};  rd_size = 3'd2; end
      8'd2: begin rd_value = uptime;                     rd_size = 3'd4; end
      8'd3: begin rd_value = HDL_BUILD;                  rd_size = 3'd4; end
      8'd4: begin rd_value = {16'd0, API_VERSION[15:0]}; rd_size = 3'd2; end
      8'd5: begin rd_value = {{(32-NUM_PAUSE_SRC){1'b0}}, live};   rd_size = 3'd1; end
      8'd6: begin rd_value = {{(32-NUM_PAUSE_SRC){1'b0}}, sticky}; rd_size = 3'd1; end
      8'd7: begin rd_value = {16'd0, uv_threshold};      rd_size = 3'd2; end
      8'd8: begin rd_value = {16'd0, uv_hysteresis};     rd_size = 3'd2; end
      8'd9: begin rd_value = '0;                         rd_size = 3'd1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      read_value <= '0;
      read_size  <= '0;
    end else if (access) begin
      read_value <= rd_value;
      read_size  <= rd_size;
    end
  end

  assign bus.slave_rdata   = read_value;
  assign bus.slave_oe      = bus.select & bus.rw;
  assign bus.slave_size    = read_size;
  assign bus.slave_size_oe = bus.select;
endmodule

// File: tb/tb_global_control_ng.sv
// Randomised bench for global_control_ng with a cycle-level behavioural model
// and a few hand-computed register reads that pin the model down.
module tb_global_control_ng;
  localparam int          CLK_HZ = 12000;
  localparam int          MS_DIV = CLK_HZ / 1000;
  localparam int          NSRC   = 2;
  localparam int          WDT_MS = 500;
  localparam logic [31:0] BUILD  = 32'hB01D_0042;
  localparam logic [15:0] API16  = 16'h000A;

  logic            clk_12MHz       = 1'b0;
  logic            reset           = 1'b1;
  logic [NSRC-1:0] pause_n_in      = '1;
  logic [15:0]     battery_voltage = 16'd2000;
  logic            global_pause;
  logic            status_led;
  logic            cmp_en          = 1'b0;
  int              n_checks        = 0;
  int              n_fail          = 0;

  global_control_ng_if bus_if();

  global_control_ng #(
    .CLK_HZ(CLK_HZ), .NUM_PAUSE_SRC(NSRC), .WDT_TIMEOUT_MS(WDT_MS),
    .HDL_BUILD(BUILD), .API_VERSION({16'd0, API16})
  ) dut (
    .clk_12MHz(clk_12MHz), .reset(reset), .bus(bus_if.slave),
    .pause_n_in(pause_n_in), .battery_voltage(battery_voltage),
    .global_pause(global_pause), .status_led(status_led)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Behavioural model: time is kept as edge and ms-tick counts, uptime and
  // blink phase are derived from them arithmetically.
  int              m_cycles = 0, m_ticks = 0, m_wdt = 0;
  logic            m_sel_prev = 1'b0, m_force = 1'b0, m_wen = 1'b0, m_exp = 1'b0;
  logic            m_uv = 1'b0, m_gp = 1'b1, m_led = 1'b0;
  logic [NSRC-1:0] m_h1 = '1, m_h2 = '1, m_sticky = '0;
  logic [15:0]     m_thr = '0, m_hyst = '0;
  logic [31:0]     m_rv = '0;
  logic [2:0]      m_rs = '0;

  function automatic logic [34:0] model_read(input logic [7:0] a, input logic [NSRC-1:0] lv);
    case (a)
      8'd0:    return {3'd1, 27'd0, m_wen, m_uv, m_exp, m_force, m_gp};
      8'd1:    return {3'd2, 16'd0, battery_voltage};
      8'd2:    return {3'd4, 32'(m_ticks / 1000)};
      8'd3:    return {3'd4, BUILD};
      8'd4:    return {3'd2, 16'd0, API16};
      8'd5:    return {3'd1, 32'(lv)};
      8'd6:    return {3'd1, 32'(m_sticky)};
      8'd7:    return {3'd2, 16'd0, m_thr};
      8'd8:    return {3'd2, 16'd0, m_hyst};
      8'd9:    return {3'd1, 32'd0};
      default: return 35'd0;
    endcase
  endfunction

  always @(posedge clk_12MHz) begin : model
    logic access, wr, wr_valid, tick, wdt_clr;
    logic [NSRC-1:0] lv;
    logic [7:0]      a;
    logic [31:0]     d;
    logic [34:0]     rd;
    access     = bus_if.select && !m_sel_prev;
    m_sel_prev = bus_if.select;
    if (reset) begin
      m_cycles = 0; m_ticks = 0; m_wdt = 0;
      m_force = 0; m_wen = 0; m_exp = 0; m_uv = 0; m_gp = 1; m_led = 0;
      m_h1 = '1; m_h2 = '1; m_sticky = '0; m_thr = '0; m_hyst = '0;
      m_rv = '0; m_rs = '0;
    end else begin
      a        = bus_if.register_addr;
      d        = bus_if.master_wdata;
      lv       = ~m_h2;
      tick     = (m_cycles % MS_DIV) == MS_DIV - 1;
      wr       = access && !bus_if.rw;
      wr_valid = wr && a <= 8'd9;
      wdt_clr  = wr_valid || !m_wen;
      if (access) begin
        rd   = model_read(a, lv);
        m_rv = rd[31:0];
        m_rs = rd[34:32];
      end
      m_led = m_uv ? ((m_ticks % 250) < 125) : (m_gp ? ((m_ticks % 1000) < 500) : 1'b1);
      m_gp  = m_force | m_exp | m_uv | (|lv);
      if (m_thr == 16'd0) m_uv = 1'b0;
      else if (battery_voltage < m_thr) m_uv = 1'b1;
      else if (int'(battery_voltage) >= int'(m_thr) + int'(m_hyst)) m_uv = 1'b0;
      if (wr && a == 8'd0 && d[2]) m_exp = 1'b0;
      else if (!wdt_clr && tick && m_wdt + 1 == WDT_MS) m_exp = 1'b1;
      if (wdt_clr) m_wdt = 0;
      else if (tick && m_wdt < WDT_MS) m_wdt = m_wdt + 1;
      m_sticky = (m_sticky & ~((wr && a == 8'd6) ? d[NSRC-1:0] : '0)) | lv;
      if (wr && a == 8'd0) begin m_force = d[1]; m_wen = d[4]; end
      if (wr && a == 8'd7) m_thr = d[15:0];
      if (wr && a == 8'd8) m_hyst = d[15:0];
      m_h2 = m_h1;
      m_h1 = pause_n_in;
      if (tick) m_ticks = m_ticks + 1;
      m_cycles = m_cycles + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk_12MHz) begin
    #2;
    if (cmp_en) begin
      checkOutput("global_pause", 32'(global_pause), 32'(m_gp));
      checkOutput("status_led", 32'(status_led), 32'(m_led));
      if (bus_if.select === 1'b1)
        checkOutput("reg_size", 32'(bus_if.reg_size), 32'(m_rs));
      if (bus_if.select === 1'b1 && bus_if.rw === 1'b1)
        checkOutput("databus", bus_if.databus, m_rv);
    end
  end

  task automatic doRead(input logic [7:0] a, output logic [31:0] v, output logic [2:0] s);
    @(negedge clk_12MHz);
    bus_if.register_addr = a;
    bus_if.rw            = 1'b1;
    bus_if.master_oe     = 1'b0;
    bus_if.select        = 1'b1;
    @(negedge clk_12MHz);
    v = bus_if.databus;
    s = bus_if.reg_size;
    bus_if.select = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_12MHz);
    bus_if.register_addr = a;
    bus_if.rw            = 1'b0;
    bus_if.master_wdata  = d;
    bus_if.master_oe     = 1'b1;
    bus_if.select        = 1'b1;
    @(negedge clk_12MHz);
    bus_if.select    = 1'b0;
    bus_if.master_oe = 1'b0;
    bus_if.rw        = 1'b1;
  endtask

  task automatic checkRead(input string name, input logic [7:0] a, input logic [31:0] ev, input logic [2:0] es);
    logic [31:0] v;
    logic [2:0]  s;
    doRead(a, v, s);
    checkOutput({name, " value"}, v, ev);
    checkOutput({name, " size"}, 32'(s), 32'(es));
  endtask

  task automatic applyStimulus(input int n_ops);
    logic [31:0] v;
    logic [2:0]  s;
    logic [7:0]  wa;
    for (int i = 0; i < n_ops; i++) begin
      @(negedge clk_12MHz);
      if ($urandom_range(0, 4) == 0) pause_n_in = NSRC'($urandom);
      if ($urandom_range(0, 2) == 0) battery_voltage = 16'($urandom_range(950, 1100));
      case ($urandom_range(0, 2))
        0: doRead(8'($urandom_range(0, 12)), v, s);
        1: begin
          case ($urandom_range(0, 5))
            0:       begin wa = 8'd0;  v = $urandom & 32'h16; end
            1:       begin wa = 8'd6;  v = $urandom; end
            2:       begin wa = 8'd7;  v = 32'($urandom_range(0, 1100)); end
            3:       begin wa = 8'd8;  v = 32'($urandom_range(0, 100)); end
            4:       begin wa = 8'd9;  v = $urandom; end
            default: begin wa = 8'd11; v = $urandom; end
          endcase
          doWrite(wa, v);
        end
        default: ;
      endcase
      repeat ($urandom_range(0, 5)) @(negedge clk_12MHz);
    end
  endtask

  initial begin : main
    logic [31:0] v;
    logic [2:0]  s;
    logic        prev;
    int          toggles;
    bus_if.register_addr = '0;
    bus_if.rw            = 1'b1;
    bus_if.select        = 1'b0;
    bus_if.master_wdata  = '0;
    bus_if.master_oe     = 1'b0;

    @(negedge clk_12MHz);
    cmp_en = 1'b1;
    repeat (3) @(negedge clk_12MHz);
    checkOutput("reset global_pause", 32'(global_pause), 32'd1);
    checkOutput("reset status_led", 32'(status_led), 32'd0);

    // First access starts on the very edge that leaves reset
    reset = 1'b0;
    bus_if.register_addr = 8'd0;
    bus_if.select        = 1'b1;
    @(negedge clk_12MHz);
    v = bus_if.databus;
    s = bus_if.reg_size;
    bus_if.select = 1'b0;
    checkOutput("status after reset value", v, 32'h01);
    checkOutput("status after reset size", 32'(s), 32'd1);
    checkRead("build", 8'd3, BUILD, 3'd4);
    checkRead("api", 8'd4, 32'h000A, 3'd2);
    checkRead("unmapped", 8'd20, 32'd0, 3'd0);
    checkRead("battery", 8'd1, 32'd2000, 3'd2);

    @(negedge clk_12MHz);
    pause_n_in = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_12MHz);
      checkOutput($sformatf("pause latency cycle %0d", k), 32'(global_pause), 32'(k == 3));
    end
    checkRead("live sources", 8'd5, 32'h02, 3'd1);
    pause_n_in = '1;
    repeat (4) @(negedge clk_12MHz);
    checkRead("sticky set", 8'd6, 32'h02, 3'd1);
    doWrite(8'd6, 32'h02);
    checkRead("sticky cleared", 8'd6, 32'h00, 3'd1);

    doWrite(8'd0, 32'h10);
    repeat (5950) @(negedge clk_12MHz);
    checkRead("wdt before expiry", 8'd0, 32'h10, 3'd1);
    repeat (100) @(negedge clk_12MHz);
    checkRead("wdt expired", 8'd0, 32'h15, 3'd1);
    doWrite(8'd0, 32'h14);
    checkRead("wdt cleared", 8'd0, 32'h10, 3'd1);
    repeat (5950) @(negedge clk_12MHz);
    doWrite(8'd9, 32'h0);
    repeat (5950) @(negedge clk_12MHz);
    checkRead("wdt kicked", 8'd0, 32'h10, 3'd1);
    repeat (6100) @(negedge clk_12MHz);
    checkRead("wdt expired again", 8'd0, 32'h15, 3'd1);
    doWrite(8'd0, 32'h04);
    checkRead("wdt disabled", 8'd0, 32'h00, 3'd1);

    while (m_cycles < 36100) @(negedge clk_12MHz);
    checkRead("uptime", 8'd2, 32'd3, 3'd4);

    doWrite(8'd7, 32'd1000);
    doWrite(8'd8, 32'd50);
    checkRead("threshold", 8'd7, 32'd1000, 3'd2);
    battery_voltage = 16'd1010;
    repeat (3) @(negedge clk_12MHz);
    checkRead("uv at 1010", 8'd0, 32'h00, 3'd1);
    battery_voltage = 16'd999;
    repeat (3) @(negedge clk_12MHz);
    checkRead("uv at 999", 8'd0, 32'h09, 3'd1);
    repeat (100) @(negedge clk_12MHz);
    toggles = 0;
    prev    = status_led;
    repeat (3000) begin
      @(negedge clk_12MHz);
      if (status_led !== prev) toggles++;
      prev = status_led;
    end
    checkOutput("led toggles in 250 ms", 32'(toggles), 32'd2);
    battery_voltage = 16'd1040;
    repeat (3) @(negedge clk_12MHz);
    checkRead("uv at 1040", 8'd0, 32'h09, 3'd1);
    battery_voltage = 16'd1050;
    repeat (3) @(negedge clk_12MHz);
    checkRead("uv at 1050", 8'd0, 32'h00, 3'd1);

    applyStimulus(400);

    // Reset in the middle of a held read cancels it
    @(negedge clk_12MHz);
    bus_if.register_addr = 8'd3;
    bus_if.rw            = 1'b1;
    bus_if.select        = 1'b1;
    @(negedge clk_12MHz);
    checkOutput("read before reset", bus_if.databus, BUILD);
    reset = 1'b1;
    repeat (3) @(negedge clk_12MHz);
    reset = 1'b0;
    @(negedge clk_12MHz);
    checkOutput("reg_size after reset", 32'(bus_if.reg_size), 32'd0);
    checkOutput("databus after reset", bus_if.databus, 32'd0);
    repeat (3) @(negedge clk_12MHz);
    checkOutput("held select no access", bus_if.databus, 32'd0);
    bus_if.select = 1'b0;
    checkRead("read after reselect", 8'd3, BUILD, 3'd4);

    repeat (5) @(negedge clk_12MHz);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
